// File: rtl/tick_pkg.sv
// Shared constants and types for the tick scheduler: default widths, channel state encoding and
// a channel-index width helper.
package tick_pkg;

  localparam int unsigned DEF_CNT_W = 29;
  localparam int unsigned DEF_N_CH  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // A single-channel scheduler still needs a 1-bit channel select port.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CH_W = ch_width(DEF_N_CH);

endpackage

// File: rtl/tick_channel.sv
// One tick channel: down-counter with staged (shadow) period, active period and run/idle FSM.
// Emits a registered one-cycle pulse each time the counter wraps on a base tick.
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             iClock,
  input  logic             iResetn,
  input  logic             iBaseTick,
  input  logic             iSync,
  input  logic             iWrHit,
  input  logic [CNT_W-1:0] iWrPeriod,
  input  logic             iEn,
  output logic             oTick,
  output logic             oPending
);

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic             r_pending;
  logic             r_tick;
  logic [CNT_W-1:0] w_load_val;

  // A write on the same edge as a load must take effect immediately.
  assign w_load_val = iWrHit ? iWrPeriod : r_shadow;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (iWrHit) begin
        r_shadow  <= iWrPeriod;
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (iEn) begin
            r_cnt     <= w_load_val;
            r_active  <= w_load_val;
            r_pending <= 1'b0;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!iEn) begin
            r_state <= ST_IDLE;
          end else if (iSync) begin
            r_cnt     <= w_load_val;
            r_active  <= w_load_val;
            r_pending <= 1'b0;
          end else if (iBaseTick) begin
            if (r_cnt == '0) begin
              r_tick <= 1'b1;
              if (r_pending || iWrHit) begin
                r_cnt     <= w_load_val;
                r_active  <= w_load_val;
                r_pending <= 1'b0;
              end else begin
                r_cnt <= r_active;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oTick    = r_tick;
  assign oPending = r_pending;

endmodule

// File: rtl/tick_scheduler.sv
// Shared time-base controller: one prescaler feeding N_CH independently programmable tick
// channels, with write-address decode for staged period updates.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int unsigned  N_CH    = DEF_N_CH,
  parameter int unsigned  CNT_W   = DEF_CNT_W,
  parameter int unsigned  PRE_DIV = 1,
  localparam int unsigned W_CH    = ch_width(N_CH)
) (
  input  logic             iClock,
  input  logic             iResetn,
  input  logic             iWrEn,
  input  logic [W_CH-1:0]  iWrCh,
  input  logic [CNT_W-1:0] iWrPeriod,
  input  logic [N_CH-1:0]  iChEn,
  input  logic             iSync,
  output logic [N_CH-1:0]  oTick,
  output logic [N_CH-1:0]  oPending
);

  localparam int unsigned PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [PRE_W-1:0] r_pre;
  logic             w_base_tick;
  logic [N_CH-1:0]  w_wr_hit;

  assign w_base_tick = (r_pre == PRE_W'(PRE_DIV - 1));

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_pre <= '0;
    end else if (iSync || w_base_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Channel indices at or above N_CH match no channel, so such writes are dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_wr_hit[g] = iWrEn && (iWrCh == W_CH'(g));

    tick_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .iClock    (iClock),
      .iResetn   (iResetn),
      .iBaseTick (w_base_tick),
      .iSync     (iSync),
      .iWrHit    (w_wr_hit[g]),
      .iWrPeriod (iWrPeriod),
      .iEn       (iChEn[g]),
      .oTick     (oTick[g]),
      .oPending  (oPending[g])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: instance A (4 channels, PRE_DIV=1) and instance B
// (3 channels, PRE_DIV=4) driven by one linear sequence with hand-computed expectations.
module tb_tick_scheduler;

  logic        clk;
  logic        rst_n;

  logic        a_wr_en;
  logic [1:0]  a_wr_ch;
  logic [28:0] a_wr_p;
  logic [3:0]  a_en;
  logic        a_sync;
  logic [3:0]  a_tick;
  logic [3:0]  a_pend;

  logic        b_wr_en;
  logic [1:0]  b_wr_ch;
  logic [28:0] b_wr_p;
  logic [2:0]  b_en;
  logic        b_sync;
  logic [2:0]  b_tick;
  logic [2:0]  b_pend;

  int          n_checks;
  int          n_fail;
  int          e;
  logic [3:0]  exp_a [0:52];

  tick_scheduler #(
    .N_CH    (4),
    .CNT_W   (29),
    .PRE_DIV (1)
  ) u_dut_a (
    .iClock    (clk),
    .iResetn   (rst_n),
    .iWrEn     (a_wr_en),
    .iWrCh     (a_wr_ch),
    .iWrPeriod (a_wr_p),
    .iChEn     (a_en),
    .iSync     (a_sync),
    .oTick     (a_tick),
    .oPending  (a_pend)
  );

  tick_scheduler #(
    .N_CH    (3),
    .CNT_W   (29),
    .PRE_DIV (4)
  ) u_dut_b (
    .iClock    (clk),
    .iResetn   (rst_n),
    .iWrEn     (b_wr_en),
    .iWrCh     (b_wr_ch),
    .iWrPeriod (b_wr_p),
    .iChEn     (b_en),
    .iSync     (b_sync),
    .oTick     (b_tick),
    .oPending  (b_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Advance instance A to edge `upto`, checking oTick against the table at every edge.
  task automatic run_a(input int upto);
    while (e < upto) begin
      step();
      chk($sformatf("a_tick@%0d", e), 32'(a_tick), 32'(exp_a[e]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    e        = 0;
    for (int k = 0; k <= 52; k++) exp_a[k] = 4'b0000;
    foreach (exp_a[k]) begin
      if (k inside {4, 8, 12, 16, 20, 22, 24, 26, 30, 38, 51}) exp_a[k][0] = 1'b1;
      if (k inside {32, 40, 46, 52}) exp_a[k][1] = 1'b1;
    end

    rst_n   = 1'b0;
    a_wr_en = 1'b0; a_wr_ch = 2'd0; a_wr_p = 29'd0; a_en = 4'b0000; a_sync = 1'b0;
    b_wr_en = 1'b0; b_wr_ch = 2'd0; b_wr_p = 29'd0; b_en = 3'b000;  b_sync = 1'b0;

    repeat (2) step();
    chk("reset_tick", 32'(a_tick), 32'd0);
    chk("reset_pend", 32'(a_pend), 32'd0);
    rst_n = 1'b1;

    // Stage P=3 on ch0 (edge -1), then enable (edge 0): ticks at 4, 8, 12, 16.
    e = -2;
    a_wr_en = 1'b1; a_wr_ch = 2'd0; a_wr_p = 29'd3;
    step();
    chk("pend_after_wr", 32'(a_pend), 32'h1);
    a_wr_en = 1'b0; a_en = 4'b0001;
    step();
    chk("pend_after_en", 32'(a_pend), 32'h0);
    chk("tick_at_en", 32'(a_tick), 32'h0);
    run_a(17);

    // Stage P=1 mid-period: old rate holds until the wrap at 20, then every 2.
    a_wr_en = 1'b1; a_wr_ch = 2'd0; a_wr_p = 29'd1;
    run_a(18);
    chk("pend_staged", 32'(a_pend), 32'h1);
    a_wr_en = 1'b0;
    run_a(19);
    chk("pend_held", 32'(a_pend), 32'h1);
    run_a(20);
    chk("pend_applied", 32'(a_pend), 32'h0);
    run_a(24);

    // Stage ch1 P=5; at edge 26 enable ch1 and write ch0 P=3 on its wrap edge.
    a_wr_en = 1'b1; a_wr_ch = 2'd1; a_wr_p = 29'd5;
    run_a(25);
    chk("pend_ch1", 32'(a_pend), 32'h2);
    a_wr_ch = 2'd0; a_wr_p = 29'd3; a_en = 4'b0011;
    run_a(26);
    chk("pend_fwd_wrap", 32'(a_pend), 32'h0);
    a_wr_en = 1'b0;
    run_a(33);

    // Sync at 34 suppresses ch0's wrap and realigns both channels.
    a_sync = 1'b1;
    run_a(34);
    a_sync = 1'b0;
    run_a(39);

    // Drop ch0 at 40 with counter=2, re-enable at 47: full period before next tick.
    a_en = 4'b0010;
    run_a(46);
    a_en = 4'b0011;
    run_a(47);
    a_wr_en = 1'b1; a_wr_ch = 2'd2; a_wr_p = 29'd7;
    run_a(48);
    a_wr_en = 1'b0;
    run_a(52);
    chk("pend_before_rst", 32'(a_pend), 32'h4);

    // Asynchronous reset while ch1's tick is high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tick", 32'(a_tick), 32'h0);
    chk("async_rst_pend", 32'(a_pend), 32'h0);
    a_en = 4'b0000;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("idle_tick", 32'(a_tick), 32'h0);
      chk("idle_pend", 32'(a_pend), 32'h0);
    end

    // Shadow reset to 0, so ch0 runs with P=0: tick every clock.
    a_en = 4'b0001;
    step();
    chk("p0_en_edge", 32'(a_tick), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("p0_cont", 32'(a_tick), 32'h1);
    end

    // Instance B: illegal channel write is ignored; ch2 P=0 with PRE_DIV=4.
    b_wr_en = 1'b1; b_wr_ch = 2'd3; b_wr_p = 29'd5;
    step();
    chk("b_illegal_wr", 32'(b_pend), 32'h0);
    b_wr_ch = 2'd2; b_wr_p = 29'd0;
    step();
    chk("b_pend_ch2", 32'(b_pend), 32'h4);
    b_wr_en = 1'b0; b_sync = 1'b1;
    step();
    chk("b_sync_idle_pend", 32'(b_pend), 32'h4);
    b_sync = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("b_pre_en_tick", 32'(b_tick), 32'h0);
    end
    b_en = 3'b100;
    step();
    chk("b_en_tick", 32'(b_tick), 32'h0);
    chk("b_en_pend", 32'(b_pend), 32'h0);
    for (int k = 5; k <= 16; k++) begin
      step();
      chk($sformatf("b_tick@s+%0d", k), 32'(b_tick), (k % 4 == 0) ? 32'h4 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
